// File: rtl/tff_mod_counter.sv
// Modulo up/down counter built from WIDTH toggle flip-flops; q <= q ^ toggle each edge.
// Optional build macro TFF_CNT_SATURATE_EN: saturate at the limits instead of wrapping.

module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk) begin
        if (!rstn) q <= RST_BIT;
        else       q <= q ^ t;
    end
endmodule

module tff_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] toggle,
    output logic             wrap,
    output logic             load_err
);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] t_up, t_dn, t_nxt;
    logic             wrap_nxt, lerr_nxt;
    logic             all1, all0;

    // Ripple-style toggle enables: bit i flips when all lower bits are 1 (up) / 0 (down).
    always_comb begin
        all1 = 1'b1;
        all0 = 1'b1;
        t_up = '0;
        t_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = all1;
            t_dn[i] = all0;
            all1    = all1 & q[i];
            all0    = all0 & ~q[i];
        end
    end

    always_comb begin
        t_nxt    = '0;
        wrap_nxt = 1'b0;
        lerr_nxt = 1'b0;
        if (load) begin
            if (32'(load_val) < MODULUS) begin
                t_nxt = q ^ load_val;
            end else begin
                t_nxt    = q ^ MAXV;
                lerr_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q == MAXV) begin
                    wrap_nxt = 1'b1;
`ifdef TFF_CNT_SATURATE_EN
                    t_nxt = '0;
`else
                    t_nxt = q;
`endif
                end else begin
                    t_nxt = t_up;
                end
            end else begin
                if (q == '0) begin
                    wrap_nxt = 1'b1;
`ifdef TFF_CNT_SATURATE_EN
                    t_nxt = '0;
`else
                    t_nxt = MAXV;
`endif
                end else begin
                    t_nxt = t_dn;
                end
            end
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        tff_cell #(.RST_BIT(RST_V[gi])) u_bit (
            .clk  (clk),
            .rstn (rstn),
            .t    (t_nxt[gi]),
            .q    (q[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            toggle   <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            toggle   <= t_nxt;
            wrap     <= wrap_nxt;
            load_err <= lerr_nxt;
        end
    end
endmodule

// File: tb/tb_tff_mod_counter.sv
// Table-driven bench for tff_mod_counter (WIDTH=4, MODULUS=10, RESET_VAL=0) with a scoreboard queue.
module tb_tff_mod_counter;
`ifdef TFF_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn, en, up, load;
    logic [3:0] load_val, q, toggle;
    logic       wrap, load_err;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q), .toggle(toggle), .wrap(wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn, en, up, load;
        logic [3:0] lv;
        logic [3:0] q, t;
        logic       w, e;
    } vec_t;

    typedef struct {
        logic [3:0] q, t;
        logic       w, e;
        int         idx;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [3:0] prev_q = 4'd0;
    int         checks = 0;
    int         failures = 0;

    // Expected toggle is derived from consecutive expected q values in the table.
    task automatic add(input logic r, input logic e_, input logic u, input logic l,
                       input int lv, input int eq, input logic ew, input logic ee);
        vec_t v;
        v.rstn = r; v.en = e_; v.up = u; v.load = l; v.lv = 4'(lv);
        v.q = 4'(eq);
        v.t = r ? (v.q ^ prev_q) : 4'd0;
        v.w = ew; v.e = ee;
        prev_q = v.q;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;

        // reset with en/load active
        add(0,1,1,1,7, 0,0,0);
        add(0,1,1,1,7, 0,0,0);
        // up count 12 clocks from 0
        for (int i = 1; i <= 9; i++) add(1,1,1,0,0, i,0,0);
        add(1,1,1,0,0, SAT ? 9 : 0, 1, 0);
        add(1,1,1,0,0, SAT ? 9 : 1, SAT, 0);
        add(1,1,1,0,0, SAT ? 9 : 2, SAT, 0);
        // load 2 then down 4
        add(1,0,1,1,2, 2,0,0);
        add(1,1,0,0,0, 1,0,0);
        add(1,1,0,0,0, 0,0,0);
        add(1,1,0,0,0, SAT ? 0 : 9, 1, 0);
        add(1,1,0,0,0, SAT ? 0 : 8, SAT, 0);
        // illegal / boundary loads
        add(1,1,1,1,12, 9,0,1);
        add(1,0,1,0,0,  9,0,0);
        add(1,1,0,1,0,  0,0,0);
        add(1,1,1,1,9,  9,0,0);
        add(1,1,1,1,10, 9,0,1);
        add(1,1,1,1,15, 9,0,1);
        add(1,0,1,1,0,  0,0,0);
        // reset mid-count overrides load
        for (int i = 1; i <= 5; i++) add(1,1,1,0,0, i,0,0);
        add(0,1,1,1,7, 0,0,0);
        add(1,1,1,0,0, 1,0,0);
        add(1,1,1,0,0, 2,0,0);
        // direction change without dead cycle, then hold
        add(1,1,1,0,0, 3,0,0);
        add(1,1,0,0,0, 2,0,0);
        add(1,1,0,0,0, 1,0,0);
        add(1,0,0,0,0, 1,0,0);
        add(1,0,1,0,0, 1,0,0);
        // up from 8 across the top limit
        add(1,0,1,1,8, 8,0,0);
        add(1,1,1,0,0, 9,0,0);
        add(1,1,1,0,0, SAT ? 9 : 0, 1, 0);
        add(1,1,1,0,0, SAT ? 9 : 1, SAT, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t x;
            rstn = vecs[i].rstn; en = vecs[i].en; up = vecs[i].up;
            load = vecs[i].load; load_val = vecs[i].lv;
            x.q = vecs[i].q; x.t = vecs[i].t; x.w = vecs[i].w; x.e = vecs[i].e; x.idx = i;
            sb.push_back(x);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
            end else begin
                x = sb.pop_front();
                chk("q",        x.idx, q,                x.q);
                chk("toggle",   x.idx, toggle,           x.t);
                chk("wrap",     x.idx, {3'b0, wrap},     {3'b0, x.w});
                chk("load_err", x.idx, {3'b0, load_err}, {3'b0, x.e});
            end
            @(negedge clk);
        end

        // hand sequence: 7->8 toggles all four bits
        load = 1'b1; load_val = 4'd7; en = 1'b0; rstn = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; en = 1'b1; up = 1'b1;
        @(posedge clk); #1;
        chk("seq_7to8_q",      0, q,      4'd8);
        chk("seq_7to8_toggle", 0, toggle, 4'b1111);
        // hand sequence: 0 -> down edge, check toggle pattern
        load = 1'b1; load_val = 4'd0; en = 1'b0;
        @(posedge clk); #1;
        load = 1'b0; en = 1'b1; up = 1'b0;
        @(posedge clk); #1;
        chk("seq_down_wrap_q",      1, q,      SAT ? 4'd0 : 4'd9);
        chk("seq_down_wrap_toggle", 1, toggle, SAT ? 4'b0000 : 4'b1001);
        chk("seq_down_wrap_pulse",  1, {3'b0, wrap}, 4'd1);
        en = 1'b0;
        @(posedge clk); #1;
        chk("seq_wrap_clears", 1, {3'b0, wrap}, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
- Parametrised modulo up/down counter whose state is held as WIDTH toggle flip-flops.
- Each clock, the block computes a per-bit toggle vector; the register updates as q <= q ^ toggle.
- Generalises the single T flip-flop to a multi-bit, direction-selectable, loadable counter with programmable modulus and wrap/error flags.
- Used as the standard small counter primitive (dividers, digit counters, timeouts) in later blocks.

Parameters:
- WIDTH, 4, counter and toggle-vector width in bits (1..16).
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- RESET_VAL, 0, value loaded on reset; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock, sole clock of the block
- rstn  input  1  synchronous active-low reset
- en  input  1  count enable; one step per clock while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load request
- load_val  input  WIDTH  value for load
- q  output  WIDTH  current count (registered)
- toggle  output  WIDTH  registered copy of the toggle vector applied at the last edge (q_new ^ q_old)
- wrap  output  1  one-cycle registered pulse: the last edge wrapped (or saturated, see option)
- load_err  output  1  one-cycle registered pulse: the last load had load_val >= MODULUS

Behaviour:
- All state changes occur on the rising edge of clk only. Reset is synchronous, active-low; there is no asynchronous path.
- Per-edge priority:
  - rstn == 0: q = RESET_VAL, toggle = 0, wrap = 0, load_err = 0.
  - load == 1 (en and up ignored):
    - if load_val < MODULUS: q = load_val, load_err = 0.
    - otherwise: q = MODULUS-1, load_err = 1.
    - In both cases wrap = 0 and toggle = q_new ^ q_old.
  - en == 1, up == 1: if q == MODULUS-1 then q = 0 and wrap = 1; else q = q+1 and wrap = 0.
  - en == 1, up == 0: if q == 0 then q = MODULUS-1 and wrap = 1; else q = q-1 and wrap = 0.
  - en == 0: q holds, toggle = 0, wrap = 0, load_err = 0.
- Toggle-vector rule (must be the implementation structure):
  - Up step, no wrap: bit i toggles iff q[i-1:0] are all 1; bit 0 always toggles.
  - Down step, no wrap: bit i toggles iff q[i-1:0] are all 0; bit 0 always toggles.
  - Wrap or load: toggle = q_old ^ q_target.
- toggle, wrap and load_err are registered and change on the same edge as q (zero-cycle skew to q).
- Latency: q reflects en/load/up one clock after they are sampled.
- Arithmetic is WIDTH bits; when MODULUS == 2**WIDTH, wrap coincides with natural binary overflow.
- q never holds a value >= MODULUS, under any input sequence.
- Reset mid-count overrides load and en on that edge. The first count after rstn rises steps from RESET_VAL.
- Changing direction mid-count takes effect on the next enabled edge; there is no dead cycle.

Optional Feature:
- Macro: TFF_CNT_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping. Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - On a saturated enabled edge, toggle = 0 and wrap pulses 1 ("limit hit").
  - load behaviour is unchanged.
- Undefined: wrap-around exactly as in Behaviour.

Test Plan:
- Reset: rstn = 0 for 2 clocks with en = 1, load = 1, load_val = 7 -> q = 0, toggle = 0, wrap = 0, load_err = 0 (RESET_VAL = 0).
- Up count, WIDTH = 4, MODULUS = 10: en = 1, up = 1 for 12 clocks from 0 -> q = 1..9, 0, 1, 2. wrap is high only on the edge where q goes 9->0. On 7->8, toggle = 4'b1111.
- Down count: load 2, then en = 1, up = 0 for 4 clocks -> q = 1, 0, 9, 8. wrap pulses on 0->9 with toggle = 4'b1001.
- Load: load = 1, load_val = 12 with en = 1 -> q = 9, load_err = 1 for one cycle. Next clock load = 0, en = 0 -> q = 9, load_err = 0.
- Reset mid-count: count to 5, assert rstn = 0 together with load = 1 -> q = 0 next edge. Release -> counting resumes 1, 2, ...
- TFF_CNT_SATURATE_EN defined: up from 8 for 3 clocks -> q = 9, 9, 9, with wrap = 1 on the 2nd and 3rd edges and toggle = 0 on those edges.
